unified_mem_arbiter: RTL and testbench

//   Shares one memory instance (async read, sync byte-masked write) between the

---
 rtl/unified_mem_arbiter.sv | 109 ++++++++++
 tb/tb_unified_mem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one async-read / sync-write memory between instruction fetch and load/store.
// Load/store wins ties until a burst limit is hit, then fetch gets one slot.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int MAX_DM_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_mask,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_valid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_request,
  output logic                mem_we_re,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W-1:0]   mem_data_out
);
  localparam int MW    = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_DM_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DM_BURST);

  typedef enum logic [1:0] {S_IDLE, S_IF, S_DM} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  dm_cnt_q, dm_cnt_d;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              burst_full;

  assign burst_full = (dm_cnt_q == CNT_MAX);

  // Grants are held low during reset so nothing reaches the memory.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst) begin
      if (dm_req && !(if_req && burst_full)) dm_gnt = 1'b1;
      else if (if_req)                       if_gnt = 1'b1;
    end
  end

  always_comb begin
    dm_cnt_d = dm_cnt_q;
    if (!if_req || if_gnt)        dm_cnt_d = '0;
    else if (dm_gnt && !burst_full) dm_cnt_d = dm_cnt_q + CNT_W'(1);
  end

  always_comb begin
    mem_request = 1'b0;
    mem_we_re   = 1'b0;
    mem_mask    = '0;
    mem_address = '0;
    mem_data_in = '0;
    if (if_gnt) begin
      mem_request = 1'b1;
      mem_address = if_addr;
    end else if (dm_gnt) begin
      mem_request = 1'b1;
      mem_we_re   = dm_we;
      mem_mask    = dm_we ? dm_mask : {MW{1'b0}};
      mem_address = dm_addr;
      mem_data_in = dm_wdata;
    end
  end

  // Owner FSM: state register / next state / outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    if (if_gnt)      state_d = S_IF;
    else if (dm_gnt) state_d = S_DM;
  end

  always_comb begin
    if_valid = (state_q == S_IF);
    dm_valid = (state_q == S_DM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_cnt_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      dm_cnt_q <= dm_cnt_d;
      if (if_gnt)            if_rdata_q <= mem_data_out;
      if (dm_gnt && !dm_we)  dm_rdata_q <= mem_data_out;
    end
  end

  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed + randomized bench for unified_mem_arbiter with a reference model
// and a behavioural memory attached to the mem_* side.
module tb_unified_mem_arbiter;
  localparam int AW = 8, DW = 32, MW = 4, MAXB = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 0, if_gnt, if_valid;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic dm_req = 0, dm_we = 0, dm_gnt, dm_valid;
  logic [MW-1:0] dm_mask = '0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, dm_rdata;
  logic mem_request, mem_we_re;
  logic [MW-1:0] mem_mask;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ref_mem [0:255];

  int n_cmp = 0, n_err = 0;
  int m_cnt = 0;
  logic m_if_vld = 0, m_dm_vld = 0;
  logic [DW-1:0] m_if_rd = '0, m_dm_rd = '0;
  logic e_if_gnt, e_dm_gnt;
  logic o_if_gnt, o_dm_gnt, o_if_vld, o_dm_vld;
  logic [DW-1:0] o_if_rd, o_dm_rd;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DM_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_mask(dm_mask), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  assign mem_data_out = mem[mem_address];

  always @(posedge clk)
    if (mem_request && mem_we_re)
      for (int b = 0; b < MW; b++)
        if (mem_mask[b]) mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, advance the model, return 1ns after the rising edge.
  task automatic cycle();
    logic [AW-1:0] e_addr;
    @(negedge clk);
    if (!rst) begin
      m_if_vld = 0; m_dm_vld = 0; m_if_rd = '0; m_dm_rd = '0; m_cnt = 0;
    end
    e_if_gnt = rst && if_req && (!dm_req || m_cnt == MAXB);
    e_dm_gnt = rst && dm_req && !e_if_gnt;
    e_addr   = e_if_gnt ? if_addr : (e_dm_gnt ? dm_addr : '0);
    o_if_gnt = if_gnt;   o_dm_gnt = dm_gnt;
    o_if_vld = if_valid; o_dm_vld = dm_valid;
    o_if_rd  = if_rdata; o_dm_rd  = dm_rdata;
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("dm_gnt", dm_gnt, e_dm_gnt);
    chk("mem_request", mem_request, e_if_gnt | e_dm_gnt);
    chk("mem_we_re", mem_we_re, e_dm_gnt & dm_we);
    chk("mem_mask", mem_mask, (e_dm_gnt && dm_we) ? dm_mask : '0);
    chk("mem_address", mem_address, e_addr);
    chk("mem_data_in", mem_data_in, e_dm_gnt ? dm_wdata : '0);
    chk("if_valid", if_valid, m_if_vld);
    chk("dm_valid", dm_valid, m_dm_vld);
    chk("if_rdata", if_rdata, m_if_rd);
    chk("dm_rdata", dm_rdata, m_dm_rd);
    if (rst) begin
      m_if_vld = e_if_gnt;
      m_dm_vld = e_dm_gnt;
      if (e_if_gnt) m_if_rd = ref_mem[if_addr];
      if (e_dm_gnt && !dm_we) m_dm_rd = ref_mem[dm_addr];
      if (e_dm_gnt && dm_we)
        for (int b = 0; b < MW; b++)
          if (dm_mask[b]) ref_mem[dm_addr][8*b +: 8] = dm_wdata[8*b +: 8];
      if (!if_req || e_if_gnt) m_cnt = 0;
      else if (e_dm_gnt)       m_cnt = (m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] v, old;
    for (int i = 0; i < 256; i++) begin
      v = $urandom; mem[i] <= v; ref_mem[i] = v;
    end
    @(posedge clk); #1;
    cycle(); cycle();
    chk("reset_if_valid", o_if_vld, 1'b0);
    chk("reset_dm_rdata", o_dm_rd, '0);
    rst = 1'b1;

    // Fetch read returns preloaded word for exactly one cycle
    mem[8'h10] <= 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    if_req = 1; if_addr = 8'h10;
    cycle(); chk("t1_gnt", o_if_gnt, 1'b1);
    if_req = 0;
    cycle(); chk("t1_valid", o_if_vld, 1'b1); chk("t1_rdata", o_if_rd, 32'hDEADBEEF);
    cycle(); chk("t1_valid_drop", o_if_vld, 1'b0);

    // Masked store touches only the low two bytes
    mem[8'h20] <= '0; ref_mem[8'h20] = '0;
    dm_req = 1; dm_we = 1; dm_mask = 4'b0011; dm_addr = 8'h20; dm_wdata = 32'h12345678;
    cycle(); chk("t2_gnt", o_dm_gnt, 1'b1);
    dm_req = 0; dm_we = 0;
    cycle();
    chk("t2_dm_valid", o_dm_vld, 1'b1);
    chk("t2_if_valid", o_if_vld, 1'b0);
    chk("t2_mem", mem[8'h20], 32'h00005678);

    // Sustained contention: four data grants then one fetch
    if_req = 1; if_addr = 8'h40; dm_req = 1; dm_addr = 8'h41;
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk("t3_seq", {o_if_gnt, o_dm_gnt}, (k % 5 == 4) ? 2'b10 : 2'b01);
    end
    if_req = 0; dm_req = 0;
    cycle();

    // Back-to-back fetches return in order
    for (int k = 0; k < 5; k++) begin
      if_req = (k < 3); if_addr = AW'(k);
      cycle();
      if (k >= 1 && k <= 3) begin
        chk("t4_valid", o_if_vld, 1'b1);
        chk("t4_rdata", o_if_rd, ref_mem[k-1]);
      end
      if (k == 4) chk("t4_valid_end", o_if_vld, 1'b0);
    end

    // Reset during a granted store: no write, counter cleared
    if_req = 1; if_addr = 8'h50; dm_req = 1; dm_we = 0; dm_addr = 8'h51;
    cycle(); cycle();
    old = ref_mem[8'h30];
    dm_we = 1; dm_mask = 4'hF; dm_addr = 8'h30; dm_wdata = ~old;
    rst = 0;
    cycle(); chk("t5_gnt", o_dm_gnt, 1'b0);
    cycle();
    chk("t5_mem", mem[8'h30], old);
    dm_we = 0; dm_addr = 8'h31;
    rst = 1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (k == 0) begin
        chk("t5_if_valid", o_if_vld, 1'b0);
        chk("t5_dm_valid", o_dm_vld, 1'b0);
      end
      chk("t5_seq", {o_if_gnt, o_dm_gnt}, (k == 4) ? 2'b10 : 2'b01);
    end
    if_req = 0; dm_req = 0;
    cycle();

    // Idle: memory side quiet, read data held
    v = o_if_rd;
    for (int k = 0; k < 10; k++) cycle();
    chk("t6_rdata_hold", o_if_rd, v);

    // Randomized traffic with cancellation
    for (int n = 0; n < 400; n++) begin
      if (if_req && $urandom_range(0, 7) == 0) if_req = 0;
      else if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1; if_addr = AW'($urandom_range(0, 15));
      end
      if (dm_req && $urandom_range(0, 7) == 0) dm_req = 0;
      else if (!dm_req && $urandom_range(0, 1) == 1) begin
        dm_req = 1; dm_we = $urandom_range(0, 1) == 1;
        dm_mask = MW'($urandom); dm_addr = AW'($urandom_range(0, 15)); dm_wdata = $urandom;
      end
      cycle();
      if (e_if_gnt) if_req = 0;
      if (e_dm_gnt) dm_req = 0;
    end
    if_req = 0; dm_req = 0;
    cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
